cordic_stage_arbiter: RTL

- Arbitrates the shared CORDIC resource (vectoring, rotation-1, rotation-2 engines) between four requesters: EVD, ICA, FFT and K-Means.
- Drives the 2-bit stage select seen by the CORDIC wrapper and issues one-hot grants.
- Tracks in-flight CORDIC operations and changes stage only after the pipeline has fully drained.
- Sits between the four algorithm controllers and the CORDIC wrapper.

---
 rtl/cordic_stage_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cordic_stage_arbiter.sv
// Round-robin owner of the shared CORDIC engines (EVD, ICA, FFT, K-Means).
// The stage select only moves after in-flight ops drain and a settle window expires.
module cordic_stage_arbiter #(
  parameter int CNT_WIDTH     = 6,
  parameter int MAX_HOLD      = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req_in,
  input  logic [3:0]           release_in,
  input  logic [3:0]           req_issue_in,
  input  logic                 issue_vec_in,
  input  logic                 issue_rot1_in,
  input  logic                 issue_rot2_in,
  input  logic                 opvld_vec_in,
  input  logic                 opvld_rot1_in,
  input  logic                 opvld_rot2_in,
  output logic [3:0]           grant_out,
  output logic [1:0]           scica_stage_out,
  output logic                 stage_vld_out,
  output logic                 busy_out,
  output logic [CNT_WIDTH-1:0] outstanding_out,
  output logic                 violation_out
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) + 1 : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1) + 1;
  localparam int CNT_MAX  = (1 << CNT_WIDTH) - 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [3:0]            grant_q, grant_d;
  logic [1:0]            stage_q, stage_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0]  out_q, out_d;
  logic                  viol_q, viol_d;
  logic [5:0]            sup_q, sup_d;

  logic       pick_vld, preempt, grant_exit, drain_done;
  logic [1:0] pick_idx, cand;
  logic [1:0] n_iss, n_ovl;
  int         net;

  // Round-robin search starting just after the last holder.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_vld && req_in[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign preempt    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) &&
                      (|(req_in & ~(4'b0001 << stage_q)));
  assign grant_exit = release_in[stage_q] || !req_in[stage_q] || preempt;
  assign drain_done = (out_q == '0) && ((SETTLE_CYCLES == 0) || (settle_cnt_q == SETTLE_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      stage_q      <= '0;
      ptr_q        <= 2'd3;
      hold_cnt_q   <= '0;
      settle_cnt_q <= '0;
      out_q        <= '0;
      viol_q       <= 1'b0;
      sup_q        <= 6'd32;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      stage_q      <= stage_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      out_q        <= out_d;
      viol_q       <= viol_d;
      sup_q        <= sup_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld)   state_d = S_GRANT;
      S_GRANT: if (grant_exit) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant and stage move together so the stage is stable on the first issue cycle.
  always_comb begin
    grant_d      = grant_q;
    stage_d      = stage_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      S_IDLE: if (pick_vld) begin
        grant_d    = 4'b0001 << pick_idx;
        stage_d    = pick_idx;
        hold_cnt_d = '0;
      end
      S_GRANT: if (grant_exit) begin
        grant_d      = '0;
        ptr_d        = stage_q;
        settle_cnt_d = '0;
      end
      S_DRAIN: begin
        if (out_q != '0)             settle_cnt_d = '0;
        else if (settle_cnt_q != '1) settle_cnt_d = settle_cnt_q + 1'b1;
      end
      default: grant_d = '0;
    endcase
  end

  // Netted in-flight count; underflow is forgiven briefly after reset for stale results.
  always_comb begin
    n_iss  = 2'(issue_vec_in) + 2'(issue_rot1_in) + 2'(issue_rot2_in);
    n_ovl  = 2'(opvld_vec_in) + 2'(opvld_rot1_in) + 2'(opvld_rot2_in);
    net    = int'(out_q) + int'(n_iss) - int'(n_ovl);
    out_d  = out_q;
    viol_d = viol_q;
    sup_d  = (sup_q != '0) ? sup_q - 6'd1 : sup_q;
    if (net < 0) begin
      out_d = '0;
      if (sup_q == '0) viol_d = 1'b1;
    end else if (net > CNT_MAX) begin
      out_d  = '1;
      viol_d = 1'b1;
    end else begin
      out_d = CNT_WIDTH'(net);
    end
    if (|(req_issue_in & ~grant_q))                        viol_d = 1'b1;
    if ((req_issue_in & (req_issue_in - 4'd1)) != 4'd0)    viol_d = 1'b1;
  end

  assign grant_out       = grant_q;
  assign scica_stage_out = stage_q;
  assign stage_vld_out   = (state_q == S_GRANT);
  assign busy_out        = (state_q != S_IDLE);
  assign outstanding_out = out_q;
  assign violation_out   = viol_q;

endmodule
